ttt_game_ctrl: RTL and testbench

//  Turn sequencer for two-player tic-tac-toe. Owns the 3x3 board state and alternates P1/P2 moves.

---
 rtl/ttt_game_ctrl_if.sv | 24 ++
 rtl/ttt_game_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ttt_game_ctrl_if.sv
// Switch-side and vga_adapter-side signals of the tic-tac-toe turn sequencer.
interface ttt_game_ctrl_if;
  logic       go;
  logic [3:0] square;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       turn;
  logic       busy;
  logic       bad_move;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output go, square,
    input  x, y, colour, plot, turn, busy, bad_move, game_over, winner
  );

  modport slave (
    input  go, square,
    output x, y, colour, plot, turn, busy, bad_move, game_over, winner
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Two-player tic-tac-toe turn sequencer: validates moves, paints the accepted
// cell through vga_adapter pixel writes and detects a win or a full board.
module ttt_game_ctrl #(
  parameter int         CELL_PX   = 16,
  parameter int         GRID_X0   = 32,
  parameter int         GRID_Y0   = 12,
  parameter logic [2:0] P1_COLOUR = 3'b100,
  parameter logic [2:0] P2_COLOUR = 3'b001
) (
  input  logic           clock,
  input  logic           resetn,
  ttt_game_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_WAIT, S_VALID, S_DRAW, S_CHECK, S_OVER} state_t;

  localparam logic [3:0] LAST = 4'(CELL_PX - 1);
  // Cell indices of the eight winning lines, one nibble per cell.
  localparam logic [11:0] LINES [8] = '{12'h012, 12'h345, 12'h678, 12'h036,
                                        12'h147, 12'h258, 12'h048, 12'h246};

  state_t          state_reg, state_next;
  logic [3:0]      sq_reg, sq_next;
  logic [8:0][1:0] board_reg, board_next;
  logic [3:0]      cx_reg, cx_next, cy_reg, cy_next;
  logic            turn_reg, turn_next;
  logic [1:0]      winner_reg, winner_next;
  logic            go_d_reg;
  logic [7:0]      x_reg, x_next;
  logic [6:0]      y_reg, y_next;
  logic [2:0]      colour_reg, colour_next;
  logic            plot_reg, plot_next;
  logic            busy_reg, busy_next;
  logic            bad_reg, bad_next;
  logic            over_reg, over_next;

  logic            rise;
  logic [1:0]      mover;
  logic [7:0]      line_hit;
  logic [8:0]      cell_full;
  logic [3:0]      row, col;

  assign rise  = bus.go & ~go_d_reg;
  assign mover = turn_reg ? 2'b10 : 2'b01;
  assign row   = sq_reg / 4'd3;
  assign col   = sq_reg % 4'd3;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      assign line_hit[gi] = (board_reg[LINES[gi][11:8]] == mover) &&
                            (board_reg[LINES[gi][7:4]]  == mover) &&
                            (board_reg[LINES[gi][3:0]]  == mover);
    end
    for (gi = 0; gi < 9; gi++) begin : g_cell
      assign cell_full[gi] = |board_reg[gi];
    end
  endgenerate

  function automatic logic illegal(input logic [3:0] sq, input logic [8:0][1:0] b);
    illegal = 1'b1;
    if (sq <= 4'd8) illegal = (b[sq] != 2'b00);
  endfunction

  always_ff @(posedge clock) begin
    // Sampled even in reset so a go level held through reset is not a fresh move.
    go_d_reg <= bus.go;
    if (!resetn) begin
      state_reg  <= S_WAIT;
      sq_reg     <= '0;
      board_reg  <= '0;
      cx_reg     <= '0;
      cy_reg     <= '0;
      turn_reg   <= 1'b0;
      winner_reg <= 2'b00;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      plot_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      bad_reg    <= 1'b0;
      over_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sq_reg     <= sq_next;
      board_reg  <= board_next;
      cx_reg     <= cx_next;
      cy_reg     <= cy_next;
      turn_reg   <= turn_next;
      winner_reg <= winner_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      colour_reg <= colour_next;
      plot_reg   <= plot_next;
      busy_reg   <= busy_next;
      bad_reg    <= bad_next;
      over_reg   <= over_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sq_next     = sq_reg;
    board_next  = board_reg;
    cx_next     = cx_reg;
    cy_next     = cy_reg;
    turn_next   = turn_reg;
    winner_next = winner_reg;
    case (state_reg)
      S_WAIT: begin
        if (rise) begin
          sq_next    = bus.square;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        if (illegal(sq_reg, board_reg)) begin
          state_next = S_WAIT;
        end else begin
          board_next[sq_reg] = mover;
          cx_next            = '0;
          cy_next            = '0;
          state_next         = S_DRAW;
        end
      end
      S_DRAW: begin
        if (cx_reg == LAST) begin
          cx_next = '0;
          if (cy_reg == LAST) state_next = S_CHECK;
          else                cy_next    = cy_reg + 4'd1;
        end else begin
          cx_next = cx_reg + 4'd1;
        end
      end
      S_CHECK: begin
        if (|line_hit) begin
          winner_next = mover;
          state_next  = S_OVER;
        end else if (&cell_full) begin
          winner_next = 2'b11;
          state_next  = S_OVER;
        end else begin
          turn_next  = ~turn_reg;
          state_next = S_WAIT;
        end
      end
      S_OVER:  state_next = S_OVER;
      default: state_next = S_WAIT;
    endcase
  end

  // Outputs are derived from the next state so the registered plot lines up with S_DRAW.
  always_comb begin
    x_next      = x_reg;
    y_next      = y_reg;
    colour_next = colour_reg;
    plot_next   = (state_next == S_DRAW);
    if (plot_next) begin
      x_next      = 8'(GRID_X0 + int'(col) * CELL_PX + int'(cx_next));
      y_next      = 7'(GRID_Y0 + int'(row) * CELL_PX + int'(cy_next));
      colour_next = (cx_next == 4'd0 || cy_next == 4'd0) ? 3'b000 :
                    (turn_reg ? P2_COLOUR : P1_COLOUR);
    end
    busy_next = !(state_next == S_WAIT || state_next == S_OVER);
    bad_next  = (state_reg == S_WAIT) && rise && illegal(bus.square, board_reg);
    over_next = (state_next == S_OVER);
  end

  assign bus.x         = x_reg;
  assign bus.y         = y_reg;
  assign bus.colour    = colour_reg;
  assign bus.plot      = plot_reg;
  assign bus.turn      = turn_reg;
  assign bus.busy      = busy_reg;
  assign bus.bad_move  = bad_reg;
  assign bus.game_over = over_reg;
  assign bus.winner    = winner_reg;
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: stimulus queues expected pixel/bad_move
// events with their cycle, a negedge monitor pops and compares them.
module tb_ttt_game_ctrl;
  localparam int LEGAL = 0;
  localparam int BAD   = 1;
  localparam int IGN   = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  ttt_game_ctrl_if bus();

  ttt_game_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_bad;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mon_en && (bus.plot === 1'b1 || bus.bad_move === 1'b1)) begin
      ev_t e;
      bit  ok;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d plot=%0b bad=%0b x=%0d y=%0d c=%b want none",
                 cyc, bus.plot, bus.bad_move, bus.x, bus.y, bus.colour);
      end else begin
        e = exp_q.pop_front();
        if (e.is_bad)
          ok = (bus.bad_move === 1'b1) && (bus.plot === 1'b0) && (cyc == e.cyc);
        else
          ok = (bus.plot === 1'b1) && (bus.bad_move === 1'b0) && (bus.x === e.x) &&
               (bus.y === e.y) && (bus.colour === e.c) && (cyc == e.cyc);
        if (!ok) begin
          errors++;
          $display("FAIL event got bad=%0b plot=%0b x=%0d y=%0d c=%b cyc=%0d want bad=%0b x=%0d y=%0d c=%b cyc=%0d",
                   bus.bad_move, bus.plot, bus.x, bus.y, bus.colour, cyc,
                   e.is_bad, e.x, e.y, e.c, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_pixels(input logic [3:0] sq, input bit p, input int first_cyc, input int count);
    ev_t e;
    int  row = int'(sq) / 3;
    int  col = int'(sq) % 3;
    for (int i = 0; i < count; i++) begin
      e.is_bad = 1'b0;
      e.x      = 8'(32 + col * 16 + (i % 16));
      e.y      = 7'(12 + row * 16 + (i / 16));
      e.c      = ((i % 16) == 0 || (i / 16) == 0) ? 3'b000 : (p ? 3'b001 : 3'b100);
      e.cyc    = first_cyc + i;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    check("rst_turn", 32'(bus.turn), 32'd0);
    check("rst_winner", 32'(bus.winner), 32'd0);
  endtask

  // One move vector: square, kind, player to move, winner expected afterwards.
  task automatic move(input logic [3:0] sq, input int kind, input bit p, input logic [1:0] win);
    int  r;
    ev_t e;
    bit  turn_exp;
    @(negedge clock);
    bus.square = sq;
    bus.go     = 1'b1;
    r          = cyc + 1;
    if (kind == LEGAL) push_pixels(sq, p, r + 1, 256);
    if (kind == BAD) begin
      e.is_bad = 1'b1; e.x = '0; e.y = '0; e.c = '0; e.cyc = r;
      exp_q.push_back(e);
    end
    @(negedge clock);
    bus.go = 1'b0;
    if (kind == LEGAL) begin
      repeat (50) @(negedge clock);
      bus.square = 4'd8;
      bus.go     = 1'b1;
      @(negedge clock);
      bus.go     = 1'b0;
      while (cyc < r + 259) @(negedge clock);
    end else begin
      while (cyc < r + 3) @(negedge clock);
    end
    turn_exp = (kind == LEGAL && win == 2'b00) ? ~p : p;
    check($sformatf("sq%0d_pending", sq), 32'(exp_q.size()), 32'd0);
    check($sformatf("sq%0d_turn", sq), 32'(bus.turn), 32'(turn_exp));
    check($sformatf("sq%0d_winner", sq), 32'(bus.winner), 32'(win));
    check($sformatf("sq%0d_game_over", sq), 32'(bus.game_over), 32'(win != 2'b00));
    check($sformatf("sq%0d_busy", sq), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    bus.go     = 1'b0;
    bus.square = 4'd0;
    resetn     = 1'b0;
    repeat (3) @(negedge clock);
    check("t1_x", 32'(bus.x), 32'd0);
    check("t1_y", 32'(bus.y), 32'd0);
    check("t1_colour", 32'(bus.colour), 32'd0);
    check("t1_plot", 32'(bus.plot), 32'd0);
    check("t1_turn", 32'(bus.turn), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_bad", 32'(bus.bad_move), 32'd0);
    check("t1_over", 32'(bus.game_over), 32'd0);
    check("t1_winner", 32'(bus.winner), 32'd0);
    mon_en = 1'b1;
    resetn = 1'b1;

    move(4'd4, LEGAL, 1'b0, 2'b00);
    check("t2_hold_x", 32'(bus.x), 32'd63);
    check("t2_hold_y", 32'(bus.y), 32'd43);
    check("t2_hold_colour", 32'(bus.colour), 32'b100);
    move(4'd4, BAD, 1'b1, 2'b00);
    move(4'd9, BAD, 1'b1, 2'b00);

    do_reset();
    move(4'd0, LEGAL, 1'b0, 2'b00);
    move(4'd3, LEGAL, 1'b1, 2'b00);
    move(4'd1, LEGAL, 1'b0, 2'b00);
    move(4'd4, LEGAL, 1'b1, 2'b00);
    move(4'd2, LEGAL, 1'b0, 2'b01);
    move(4'd5, IGN, 1'b0, 2'b01);
    move(4'd2, IGN, 1'b0, 2'b01);

    do_reset();
    move(4'd0, LEGAL, 1'b0, 2'b00);
    move(4'd1, LEGAL, 1'b1, 2'b00);
    move(4'd2, LEGAL, 1'b0, 2'b00);
    move(4'd4, LEGAL, 1'b1, 2'b00);
    move(4'd3, LEGAL, 1'b0, 2'b00);
    move(4'd5, LEGAL, 1'b1, 2'b00);
    move(4'd7, LEGAL, 1'b0, 2'b00);
    move(4'd6, LEGAL, 1'b1, 2'b00);
    move(4'd8, LEGAL, 1'b0, 2'b11);

    do_reset();
    move(4'd2, LEGAL, 1'b0, 2'b00);
    move(4'd0, LEGAL, 1'b1, 2'b00);
    move(4'd4, LEGAL, 1'b0, 2'b00);
    move(4'd1, LEGAL, 1'b1, 2'b00);
    move(4'd6, LEGAL, 1'b0, 2'b01);

    // Reset lands on the 100th draw cycle with go still held high.
    do_reset();
    @(negedge clock);
    bus.square = 4'd7;
    bus.go     = 1'b1;
    r          = cyc + 1;
    push_pixels(4'd7, 1'b0, r + 1, 100);
    while (cyc < r + 100) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("t6_plot", 32'(bus.plot), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("t6_no_rise_busy", 32'(bus.busy), 32'd0);
    check("t6_turn", 32'(bus.turn), 32'd0);
    bus.go = 1'b0;
    move(4'd7, LEGAL, 1'b0, 2'b00);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
